// File: rtl/mac_operand_feeder_if.sv
// Bundle of the feeder's control, operand-FIFO and MAC-side signals.
// master = the feeder, slave = the surrounding datapath (FIFOs, MAC, controller).
interface mac_operand_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                    start;
  logic [LEN_WIDTH-1:0]    len;
  logic                    busy;
  logic                    done;
  logic [3*DATA_WIDTH-1:0] result;
  logic                    a_empty;
  logic [DATA_WIDTH-1:0]   a_rdata;
  logic                    a_rden;
  logic                    b_empty;
  logic [DATA_WIDTH-1:0]   b_rdata;
  logic                    b_rden;
  logic                    mac_en;
  logic                    mac_clr;
  logic [DATA_WIDTH-1:0]   mac_a;
  logic [DATA_WIDTH-1:0]   mac_b;
  logic [3*DATA_WIDTH-1:0] mac_cout;

  modport master (
    input  start, len, a_empty, a_rdata, b_empty, b_rdata, mac_cout,
    output busy, done, result, a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b
  );

  modport slave (
    output start, len, a_empty, a_rdata, b_empty, b_rdata, mac_cout,
    input  busy, done, result, a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// Clears the MAC, streams len A/B pairs from two show-ahead FIFOs into it,
// then captures the accumulated Cout as the dot-product result.
module mac_operand_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  mac_operand_feeder_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    en_q, en_d;
  logic                    clr_q, clr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [3*DATA_WIDTH-1:0] res_q, res_d;
  logic                    pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Registered MAC controls are computed one state ahead, so each strobe
  // lands in the cycle the state diagram associates with it.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            rem_d   = bus.len;
            busy_d  = 1'b1;
            clr_d   = 1'b1;
            state_d = CLEAR;
          end else begin
            done_d = 1'b1;
            res_d  = '0;
          end
        end
      end
      CLEAR: state_d = FEED;
      FEED: begin
        // Pop only when both heads are valid so A and B never drift apart.
        pop = !bus.a_empty && !bus.b_empty;
        if (pop) begin
          en_d  = 1'b1;
          a_d   = bus.a_rdata;
          b_d   = bus.b_rdata;
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: state_d = CAPTURE;
      CAPTURE: begin
        res_d   = bus.mac_cout;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.a_rden  = pop;
  assign bus.b_rden  = pop;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = res_q;
  assign bus.mac_en  = en_q;
  assign bus.mac_clr = clr_q;
  assign bus.mac_a   = a_q;
  assign bus.mac_b   = b_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench: behavioural FIFOs and MAC around the feeder, expected results
// queued at start and compared when done pulses.
module tb_mac_operand_feeder;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_operand_feeder_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mac_operand_feeder #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // show-ahead FIFO models
  logic [DW-1:0] a_mem [64];
  logic [DW-1:0] b_mem [64];
  int a_wp = 0, b_wp = 0, a_rp = 0, b_rp = 0;
  logic b_stall = 1'b0;
  logic flush = 1'b0;
  assign bus.a_empty = (a_rp == a_wp);
  assign bus.b_empty = (b_rp == b_wp) || b_stall;
  assign bus.a_rdata = a_mem[a_rp];
  assign bus.b_rdata = b_mem[b_rp];
  always @(posedge clk) begin
    if (flush) begin
      a_rp <= a_wp;
      b_rp <= b_wp;
    end else begin
      if (bus.a_rden) a_rp <= a_rp + 1;
      if (bus.b_rden) b_rp <= b_rp + 1;
    end
  end

  // MAC model
  logic [3*DW-1:0] cout = '0;
  assign bus.mac_cout = cout;
  always @(posedge clk) begin
    if (bus.mac_clr)     cout <= '0;
    else if (bus.mac_en) cout <= cout + bus.mac_a * bus.mac_b;
  end

  // scoreboard
  logic [3*DW-1:0] exp_res [$];
  int              exp_cyc [$];
  int rden_cnt = 0, en_cnt = 0, clr_cnt = 0;
  int last_rden = -1, last_en = -1, last_clr = -1;

  always @(negedge clk) begin
    logic [3*DW-1:0] r;
    int c;
    checks++;
    assert (bus.a_rden === bus.b_rden) else begin
      failures++; $error("FAIL rden_pair cyc=%0d a_rden=%b b_rden=%b", cyc, bus.a_rden, bus.b_rden);
    end
    checks++;
    assert ((bus.mac_en && bus.mac_clr) === 1'b0) else begin
      failures++; $error("FAIL en_clr_overlap cyc=%0d got=1 want=0", cyc);
    end
    if (bus.a_rden)  begin rden_cnt++; last_rden = cyc; end
    if (bus.mac_en)  begin en_cnt++;   last_en   = cyc; end
    if (bus.mac_clr) begin clr_cnt++;  last_clr  = cyc; end
    if (bus.done === 1'b1) begin
      if (exp_res.size() == 0) begin
        checks++; failures++;
        $error("FAIL unexpected_done cyc=%0d result=%0d want=no_done", cyc, bus.result);
      end else begin
        r = exp_res.pop_front();
        c = exp_cyc.pop_front();
        checks++;
        assert (bus.result === r) else begin
          failures++; $error("FAIL result cyc=%0d got=%0d want=%0d", cyc, bus.result, r);
        end
        checks++;
        assert (cyc === c) else begin
          failures++; $error("FAIL done_cycle got=%0d want=%0d", cyc, c);
        end
      end
    end
  end

  logic [3*DW-1:0] esum;
  int t0;
  int n0_rden, n0_en, n0_clr;

  task automatic load(input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_mem[a_wp] = a; a_wp++;
    b_mem[b_wp] = b; b_wp++;
    esum = esum + (3*DW)'(int'(a) * int'(b));
  endtask

  task automatic snap();
    n0_rden = rden_cnt; n0_en = en_cnt; n0_clr = clr_cnt;
  endtask

  // Leaves the bench in cycle t0+1 (just after the start cycle).
  task automatic start_run(input int n, input bit push, input int done_off);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = LW'(n);
    t0 = cyc;
    if (push) begin
      exp_res.push_back(esum);
      exp_cyc.push_back(t0 + done_off);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_sb(input string tag, input int budget);
    for (int i = 0; i < budget && exp_res.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (exp_res.size() == 0) else begin
      failures++; $error("FAIL %s_timeout pending=%0d want=0", tag, exp_res.size());
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++; $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len   = '0;
    esum      = '0;

    // reset state
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_en",   32'(bus.mac_en), 0);
    chk("rst_clr",  32'(bus.mac_clr), 0);
    chk("rst_res",  32'(bus.result), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: single pair, latency of every strobe
    esum = '0; load(8'd2, 8'd2); snap();
    start_run(1, 1'b1, 5);
    wait_sb("t1", 40);
    chk("t1_clr_cyc",  32'(last_clr),  32'(t0 + 1));
    chk("t1_rden_cyc", 32'(last_rden), 32'(t0 + 2));
    chk("t1_en_cyc",   32'(last_en),   32'(t0 + 3));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_hold", 32'(bus.result), 4);
    chk("t1_busy_end", 32'(bus.busy), 0);

    // 2: three pairs, no stall
    esum = '0; load(8'd1, 8'd4); load(8'd2, 8'd5); load(8'd3, 8'd6); snap();
    start_run(3, 1'b1, 7);
    @(negedge clk);
    chk("t2_busy", 32'(bus.busy), 1);
    wait_sb("t2", 40);
    chk("t2_rden_n", 32'(rden_cnt - n0_rden), 3);
    chk("t2_en_n",   32'(en_cnt - n0_en), 3);
    chk("t2_clr_n",  32'(clr_cnt - n0_clr), 1);

    // 3: B empty for 4 cycles after the first pop
    esum = '0; load(8'd1, 8'd4); load(8'd2, 8'd5); load(8'd3, 8'd6); snap();
    start_run(3, 1'b1, 11);
    @(posedge clk); #1;
    @(posedge clk); #1 b_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) chk("t3_stall_en", 32'(bus.mac_en), 0);
      @(posedge clk); #1;
    end
    b_stall = 1'b0;
    wait_sb("t3", 40);
    chk("t3_rden_n", 32'(rden_cnt - n0_rden), 3);
    chk("t3_en_n",   32'(en_cnt - n0_en), 3);

    // 4: len=0 completes immediately with no pops or clear
    esum = '0; snap();
    start_run(0, 1'b1, 1);
    @(negedge clk);
    chk("t4_busy", 32'(bus.busy), 0);
    wait_sb("t4", 10);
    chk("t4_rden_n", 32'(rden_cnt - n0_rden), 0);
    chk("t4_clr_n",  32'(clr_cnt - n0_clr), 0);

    // 5: back-to-back runs must clear the accumulator; start mid-run ignored
    esum = '0; load(8'd2, 8'd2);
    start_run(1, 1'b1, 5);
    wait_sb("t5a", 40);
    esum = '0; load(8'd4, 8'd4); snap();
    start_run(1, 1'b1, 5);
    bus.start = 1'b1; bus.len = LW'(5);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_sb("t5b", 40);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_after", 32'(bus.busy), 0);
    chk("t5_en_n", 32'(en_cnt - n0_en), 1);

    // 6: async reset mid-FEED, then a fresh run
    esum = '0; load(8'd1, 8'd4); load(8'd2, 8'd5); load(8'd3, 8'd6); snap();
    start_run(3, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("t6_pops_before", 32'(rden_cnt - n0_rden), 1);
    chk("t6_busy",  32'(bus.busy), 0);
    chk("t6_en",    32'(bus.mac_en), 0);
    chk("t6_mac_a", 32'(bus.mac_a), 0);
    chk("t6_mac_b", 32'(bus.mac_b), 0);
    chk("t6_res",   32'(bus.result), 0);
    chk("t6_rden",  32'(bus.a_rden), 0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; rst_n = 1'b1;
    esum = '0; load(8'd3, 8'd5);
    start_run(1, 1'b1, 5);
    wait_sb("t6", 40);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
